// File: rtl/cnna_acc_pkg.sv
// Shared widths, FSM state type and saturation limit for the accumulate/requantize block.
package cnna_acc_pkg;

   localparam int unsigned IN_W    = 35;
   localparam int unsigned ACC_W   = 48;
   localparam int unsigned OUT_W   = 8;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned SHIFT_W = 6;

   localparam int unsigned OUT_MAX = (1 << OUT_W) - 1;

   typedef enum logic [1:0] {
      ACC,
      RQ,
      EMIT
   } state_e;

endpackage

// File: rtl/cnna_requant_core.sv
// Combinational round / right-shift / saturate of a finished accumulator value.
// CNNA_ACC_ROUND_EN enables the round-half-up addend; otherwise the shift truncates.
module cnna_requant_core
   import cnna_acc_pkg::*;
#(
   parameter int unsigned ACC_W   = cnna_acc_pkg::ACC_W,
   parameter int unsigned OUT_W   = cnna_acc_pkg::OUT_W,
   parameter int unsigned SHIFT_W = cnna_acc_pkg::SHIFT_W
) (
   input  logic [ACC_W-1:0]   acc,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               ovf,
   output logic [OUT_W-1:0]   data,
   output logic               sat
);

`ifdef CNNA_ACC_ROUND_EN
   localparam int unsigned QW = ACC_W + 1;
`else
   localparam int unsigned QW = ACC_W;
`endif

   localparam logic [QW-1:0] QMAX = QW'((1 << OUT_W) - 1);

   logic [QW-1:0] q;
   logic          q_big;

`ifdef CNNA_ACC_ROUND_EN
   logic [QW-1:0] addend;
   logic [QW-1:0] r;

   always_comb begin
      addend = '0;
      if (shift != '0) begin
         addend = QW'(1) << (shift - SHIFT_W'(1));
      end
      // One extra bit so the rounding carry never wraps.
      r = QW'(acc) + addend;
      if (int'(shift) >= int'(ACC_W)) begin
         q = '0;
      end else begin
         q = r >> shift;
      end
   end
`else
   always_comb begin
      q = acc >> shift;
   end
`endif

   always_comb begin
      q_big = (q > QMAX);
      data  = q_big ? {OUT_W{1'b1}} : q[OUT_W-1:0];
      sat   = q_big || ovf;
   end

endmodule

// File: rtl/cnna_acc_requant.sv
// Accumulates cfg_len products, requantizes the sum and emits an 8-bit activation.
// Rounding is selected at build time by CNNA_ACC_ROUND_EN (see cnna_requant_core).
module cnna_acc_requant
   import cnna_acc_pkg::*;
#(
   parameter int unsigned IN_W    = cnna_acc_pkg::IN_W,
   parameter int unsigned ACC_W   = cnna_acc_pkg::ACC_W,
   parameter int unsigned OUT_W   = cnna_acc_pkg::OUT_W,
   parameter int unsigned CNT_W   = cnna_acc_pkg::CNT_W,
   parameter int unsigned SHIFT_W = cnna_acc_pkg::SHIFT_W
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic [CNT_W-1:0]   cfg_len,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_sat
);

   state_e             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   len_q;
   logic [SHIFT_W-1:0] shift_q;
   logic               ovf_q;

   logic [ACC_W:0]     sum;
   logic [CNT_W-1:0]   cur_len;
   logic [CNT_W-1:0]   cnt_inc;
   logic [OUT_W-1:0]   rq_data;
   logic               rq_sat;
   logic               accept;

   always_comb begin
      in_ready = (state_q == ACC);
      accept   = in_valid && in_ready;
      sum      = {1'b0, acc_q} + (ACC_W + 1)'(in_data);
      cnt_inc  = cnt_q + CNT_W'(1);
      // The group length comes straight from config on the first product of a group.
      if (cnt_q == '0) begin
         cur_len = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
      end else begin
         cur_len = len_q;
      end
   end

   cnna_requant_core #(
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
   ) u_core (
      .acc   (acc_q),
      .shift (shift_q),
      .ovf   (ovf_q),
      .data  (rq_data),
      .sat   (rq_sat)
   );

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q   <= ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         shift_q   <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         unique case (state_q)
            ACC: begin
               if (accept) begin
                  if (cnt_q == '0) begin
                     len_q   <= cur_len;
                     shift_q <= cfg_shift;
                  end
                  if (sum[ACC_W]) begin
                     acc_q <= {ACC_W{1'b1}};
                     ovf_q <= 1'b1;
                  end else begin
                     acc_q <= sum[ACC_W-1:0];
                  end
                  if (cnt_inc == cur_len) begin
                     cnt_q   <= '0;
                     state_q <= RQ;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            RQ: begin
               out_data  <= rq_data;
               out_sat   <= rq_sat;
               out_valid <= 1'b1;
               state_q   <= EMIT;
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc_q     <= '0;
                  ovf_q     <= 1'b0;
                  state_q   <= ACC;
               end
            end
            default: state_q <= ACC;
         endcase
      end
   end

endmodule
